// File: rtl/snake_dir_ctrl.sv
// Direction-input front end for the snake engine: synchronizes and debounces the
// buttons, filters illegal turns, queues up to two turns and issues the game tick.
module snake_dir_ctrl #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int TICK_CYCLES     = 5000000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       up,
    input  logic       right,
    input  logic       down,
    input  logic       left,
    input  logic       enable,
    output logic       tick,
    output logic [2:0] move,
    output logic [1:0] queue_count,
    output logic       dropped
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam int TW = $clog2(TICK_CYCLES);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);
    localparam logic [2:0]    MOVE_IDLE = 3'd5;

    // Bit i of every button vector corresponds to move code i+1.
    logic [3:0] raw;
    assign raw = {left, down, right, up};

    logic [3:0]    sync1_q, sync2_q;
    logic [3:0]    stable_q, stable_d;
    logic [3:0]    prev_q;
    logic [DW-1:0] deb_cnt_q [4];
    logic [DW-1:0] deb_cnt_d [4];

    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic          tick_q, tick_d;
    logic [2:0]    move_q, move_d;
    logic          dropped_q, dropped_d;
    logic [2:0]    mem_q [2];
    logic [2:0]    mem_d [2];
    logic          wr_ptr_q, wr_ptr_d;
    logic          rd_ptr_q, rd_ptr_d;
    logic [1:0]    count_q, count_d;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            stable_d[i]  = stable_q[i];
            deb_cnt_d[i] = '0;
            if (sync2_q[i] != stable_q[i]) begin
                if (deb_cnt_q[i] == DEB_LAST) begin
                    stable_d[i] = ~stable_q[i];
                end else begin
                    deb_cnt_d[i] = deb_cnt_q[i] + DW'(1);
                end
            end
        end
    end

    logic [3:0] press;
    logic [2:0] cand;
    logic       losers;

    always_comb begin
        press  = stable_q & ~prev_q;
        cand   = 3'd0;
        losers = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (press[i]) begin
                if (cand == 3'd0) begin
                    cand = 3'(i + 1);
                end else begin
                    losers = 1'b1;
                end
            end
        end
    end

    logic [2:0] ref_dir;
    logic [3:0] diff;
    logic       wrap, pop, legal, room, push;

    // The reference is the pre-pop tail, so a turn arriving on a tick edge is
    // judged against what was queued last, not against the move being issued.
    always_comb begin
        ref_dir = (count_q != 2'd0) ? mem_q[~wr_ptr_q] : move_q;
        diff    = {1'b0, cand} - {1'b0, ref_dir};
        wrap    = enable && (tick_cnt_q == TICK_LAST);
        pop     = wrap && (count_q != 2'd0);
        legal   = (ref_dir == MOVE_IDLE) ||
                  ((cand != ref_dir) && (diff != 4'd2) && (diff != 4'he));
        room    = (count_q != 2'd2) || pop;
        push    = enable && (cand != 3'd0) && legal && room;
    end

    always_comb begin
        tick_cnt_d = '0;
        tick_d     = 1'b0;
        move_d     = move_q;
        dropped_d  = 1'b0;
        mem_d      = mem_q;
        wr_ptr_d   = 1'b0;
        rd_ptr_d   = 1'b0;
        count_d    = 2'd0;
        if (enable) begin
            tick_cnt_d = wrap ? '0 : tick_cnt_q + TW'(1);
            tick_d     = wrap;
            dropped_d  = losers || ((cand != 3'd0) && !(legal && room));
            wr_ptr_d   = wr_ptr_q;
            rd_ptr_d   = rd_ptr_q;
            if (pop) begin
                move_d   = mem_q[rd_ptr_q];
                rd_ptr_d = ~rd_ptr_q;
            end
            if (push) begin
                mem_d[wr_ptr_q] = cand;
                wr_ptr_d        = ~wr_ptr_q;
            end
            count_d = count_q + 2'(push) - 2'(pop);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            stable_q   <= '0;
            prev_q     <= '0;
            for (int i = 0; i < 4; i++) deb_cnt_q[i] <= '0;
            tick_cnt_q <= '0;
            tick_q     <= 1'b0;
            move_q     <= MOVE_IDLE;
            dropped_q  <= 1'b0;
            for (int i = 0; i < 2; i++) mem_q[i] <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
        end else begin
            sync1_q    <= raw;
            sync2_q    <= sync1_q;
            stable_q   <= stable_d;
            prev_q     <= stable_q;
            for (int i = 0; i < 4; i++) deb_cnt_q[i] <= deb_cnt_d[i];
            tick_cnt_q <= tick_cnt_d;
            tick_q     <= tick_d;
            move_q     <= move_d;
            dropped_q  <= dropped_d;
            for (int i = 0; i < 2; i++) mem_q[i] <= mem_d[i];
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    assign tick        = tick_q;
    assign move        = move_q;
    assign queue_count = count_q;
    assign dropped     = dropped_q;

endmodule

// File: tb/tb_snake_dir_ctrl.sv
// Bench for snake_dir_ctrl: directed scenarios followed by random button traffic,
// all checked cycle by cycle against a queue-based reference model.
module tb_snake_dir_ctrl;

    localparam int DEB  = 4;
    localparam int TICK = 10;

    logic       clock = 1'b0;
    logic       reset;
    logic       up, right, down, left;
    logic       enable;
    logic       tick;
    logic [2:0] move;
    logic [1:0] queue_count;
    logic       dropped;

    snake_dir_ctrl #(.DEBOUNCE_CYCLES(DEB), .TICK_CYCLES(TICK)) dut (
        .clock(clock), .reset(reset),
        .up(up), .right(right), .down(down), .left(left),
        .enable(enable),
        .tick(tick), .move(move), .queue_count(queue_count), .dropped(dropped)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;
    int drops_seen  = 0;
    int ticks_seen  = 0;

    // Reference model state
    int m_s1[4], m_s2[4], m_stab[4], m_cnt[4], m_prev[4];
    int m_q[$];
    int m_mv, m_tcnt, m_tk, m_drp;

    task automatic check(input string tag, input logic [7:0] obs, input int exp);
        total++;
        assert (obs === 8'(exp)) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_s1[i] = 0; m_s2[i] = 0; m_stab[i] = 0; m_cnt[i] = 0; m_prev[i] = 0;
        end
        m_q.delete();
        m_mv = 5; m_tcnt = 0; m_tk = 0; m_drp = 0;
    endtask

    task automatic model_step(input logic [3:0] r, input logic en);
        int  cand, refv, d;
        bit  losers, acc, wrap, pop;
        cand = 0; losers = 0; acc = 0;
        for (int i = 0; i < 4; i++)
            if (m_stab[i] == 1 && m_prev[i] == 0) begin
                if (cand == 0) cand = i + 1;
                else losers = 1;
            end
        wrap = en && (m_tcnt == TICK - 1);
        pop  = wrap && (m_q.size() > 0);
        if (cand != 0) begin
            refv = (m_q.size() > 0) ? m_q[$] : m_mv;
            d = cand - refv;
            if (d < 0) d = -d;
            acc = (refv == 5) || (d != 0 && d != 2 && (m_q.size() < 2 || pop));
        end
        if (en) begin
            m_drp = (losers || (cand != 0 && !acc)) ? 1 : 0;
            if (pop) begin
                m_mv = m_q[0];
                void'(m_q.pop_front());
            end
            if (cand != 0 && acc) m_q.push_back(cand);
            m_tk   = wrap ? 1 : 0;
            m_tcnt = wrap ? 0 : m_tcnt + 1;
        end else begin
            m_drp = 0; m_q.delete(); m_tk = 0; m_tcnt = 0;
        end
        for (int i = 0; i < 4; i++) begin
            m_prev[i] = m_stab[i];
            if (m_s2[i] != m_stab[i]) begin
                if (m_cnt[i] == DEB - 1) begin
                    m_stab[i] = 1 - m_stab[i];
                    m_cnt[i]  = 0;
                end else begin
                    m_cnt[i]++;
                end
            end else begin
                m_cnt[i] = 0;
            end
            m_s2[i] = m_s1[i];
            m_s1[i] = int'(r[i]);
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".tick"},    8'(tick),        m_tk);
        check({tag, ".move"},    8'(move),        m_mv);
        check({tag, ".count"},   8'(queue_count), m_q.size());
        check({tag, ".dropped"}, 8'(dropped),     m_drp);
    endtask

    task automatic cyc(input int n);
        logic [3:0] r;
        logic       en;
        for (int k = 0; k < n; k++) begin
            r  = {left, down, right, up};
            en = enable;
            @(posedge clock);
            model_step(r, en);
            #1;
            check_outputs("cyc");
            if (dropped === 1'b1) drops_seen++;
            if (tick === 1'b1) ticks_seen++;
        end
    endtask

    task automatic wait_tick();
        bit found;
        found = 0;
        for (int g = 0; g < 50 && !found; g++) begin
            cyc(1);
            if (tick === 1'b1) found = 1;
        end
        check("wait_tick", 8'(found), 1);
    endtask

    task automatic pulse_reset(input string tag);
        reset = 1'b1;
        #1;
        model_reset();
        check_outputs(tag);
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        reset = 1'b1; enable = 1'b1;
        up = 1'b0; right = 1'b0; down = 1'b0; left = 1'b0;
        model_reset();
        #1;
        check_outputs("reset");
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset = 1'b0;

        // 1: idle ticks at cycles 10, 20, 30
        ticks_seen = 0;
        cyc(30);
        check("s1.ticks", 8'(ticks_seen), 3);
        check("s1.tick30", 8'(tick), 1);
        check("s1.move", 8'(move), 5);

        // 2: clean right press, pushed 7 cycles later, issued on next tick
        right = 1'b1;
        cyc(6);
        check("s2.count_before", 8'(queue_count), 0);
        cyc(1);
        check("s2.count_push", 8'(queue_count), 1);
        cyc(3);
        check("s2.move", 8'(move), 2);
        check("s2.count_pop", 8'(queue_count), 0);
        cyc(10);
        right = 1'b0;
        cyc(10);

        // 3: reversal rejected, then two legal turns queued
        drops_seen = 0;
        left = 1'b1;
        cyc(12);
        left = 1'b0;
        cyc(10);
        check("s3.drops", 8'(drops_seen), 1);
        check("s3.count0", 8'(queue_count), 0);
        wait_tick();
        up = 1'b1;
        cyc(1);
        left = 1'b1;
        cyc(7);
        check("s3.count2", 8'(queue_count), 2);
        cyc(2);
        check("s3.move_up", 8'(move), 1);
        cyc(10);
        check("s3.move_left", 8'(move), 4);
        up = 1'b0; left = 1'b0;
        cyc(10);

        // 4: bouncing shorter than the debounce window
        drops_seen = 0;
        for (int i = 0; i < 15; i++) begin
            up = ~up;
            cyc(2);
        end
        up = 1'b0;
        cyc(10);
        check("s4.count", 8'(queue_count), 0);
        check("s4.drops", 8'(drops_seen), 0);
        check("s4.move", 8'(move), 4);

        // 5a: third press against a full queue is dropped
        wait_tick();
        up = 1'b1;
        cyc(1);
        right = 1'b1;
        cyc(1);
        down = 1'b1;
        cyc(6);
        check("s5a.count2", 8'(queue_count), 2);
        cyc(1);
        check("s5a.dropped", 8'(dropped), 1);
        check("s5a.count_full", 8'(queue_count), 2);
        cyc(1);
        check("s5a.move", 8'(move), 1);
        up = 1'b0; right = 1'b0; down = 1'b0;
        wait_tick();
        check("s5a.move2", 8'(move), 2);

        // 5b: push lands on the same edge as a tick pop
        up = 1'b1;
        cyc(1);
        left = 1'b1;
        cyc(2);
        down = 1'b1;
        cyc(7);
        check("s5b.tick", 8'(tick), 1);
        check("s5b.move", 8'(move), 1);
        check("s5b.count", 8'(queue_count), 2);
        check("s5b.dropped", 8'(dropped), 0);
        up = 1'b0; left = 1'b0; down = 1'b0;
        cyc(20);
        check("s5b.move_down", 8'(move), 3);

        // 6: asynchronous reset with a full queue, then enable held low
        right = 1'b1;
        cyc(1);
        up = 1'b1;
        cyc(7);
        check("s6.count2", 8'(queue_count), 2);
        check("s6.move3", 8'(move), 3);
        right = 1'b0; up = 1'b0;
        pulse_reset("s6.reset");
        enable = 1'b0;
        ticks_seen = 0;
        cyc(15);
        check("s6.ticks", 8'(ticks_seen), 0);
        check("s6.count", 8'(queue_count), 0);
        enable = 1'b1;

        // Random traffic
        for (int n = 0; n < 2500; n++) begin
            if ($urandom_range(0, 7) == 0) up    = ~up;
            if ($urandom_range(0, 7) == 0) right = ~right;
            if ($urandom_range(0, 7) == 0) down  = ~down;
            if ($urandom_range(0, 7) == 0) left  = ~left;
            if (enable) begin
                if ($urandom_range(0, 149) == 0) enable = 1'b0;
            end else begin
                if ($urandom_range(0, 9) == 0) enable = 1'b1;
            end
            if ($urandom_range(0, 699) == 0) pulse_reset("rnd.reset");
            cyc(1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/snake_dir_ctrl.md
# snake_dir_ctrl

Input-conditioning stage between the board push-buttons and the snake game engine. It synchronizes and debounces the four direction buttons, rejects illegal turns (repeat or 180° reversal), buffers up to two pending turns, and generates the game-step tick. On each tick it presents the next move code to the engine. The move code is 1=up, 2=right, 3=down, 4=left, 5=idle.

## Interface
- DEBOUNCE_CYCLES, 250000: consecutive stable cycles required before a button level change is accepted (5 ms at 50 MHz). Must be ≥ 2.
- TICK_CYCLES, 5000000: clock cycles per game step (10 Hz at 50 MHz). Must be ≥ 4.
- clock  in  1  system clock; one clock domain; every flop is on its rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- up, right, down, left  in  1 each  raw active-high buttons; asynchronous to clock.
- enable  in  1  game running. When low: tick counter held at 0, queue flushed, move held.
- tick  out  1  one-cycle pulse per game step.
- move  out  3  current direction code; changes only in a cycle where tick=1.
- queue_count  out  2  pending turns, 0..2.
- dropped  out  1  one-cycle pulse when a debounced press is discarded.

## Operation
- Sync: 2-flop synchronizer per button. Reset value is 0.
- Debounce: each button has a stable level and a counter.
  - When the synced level ≠ the stable level, the counter increments.
  - When the counter reaches DEBOUNCE_CYCLES-1 and the levels still differ, the stable level flips and the counter clears.
  - Any cycle where the synced level equals the stable level clears the counter.
- Press: a rising edge of a stable level.
  - If several presses occur in the same cycle, priority is up > right > down > left. The winner is the candidate; each loser raises dropped.
- Acceptance: compare the candidate against ref. ref = queue tail if queue_count > 0, otherwise move.
  - Accept if ref=5.
  - Reject if candidate = ref, or |candidate − ref| = 2 (reversal).
  - Reject if queue_count = 2.
  - Accepted candidates are pushed to the tail. Rejected candidates set dropped=1 on the next cycle.
- Tick counter: counts 0..TICK_CYCLES-1 while enable=1.
  - At wrap, tick is registered high for one cycle.
  - On that same edge, if the queue is non-empty, move ← head and the head is popped. If the queue is empty, move is unchanged.
- Simultaneous push and pop in one cycle: both take effect and queue_count is unchanged. ref is the pre-pop tail.
- enable falling: on the next edge, the queue is cleared, the counter goes to 0, tick goes to 0, and move is held. Debounce logic keeps running. Presses while enable=0 are discarded silently, with no dropped pulse.
- Queue: 2-entry circular FIFO with 1-bit read and write pointers plus the count.

## Timing
- Reset values: tick=0, move=5, queue_count=0, dropped=0. All debounce counters, stable levels, sync flops and tick counter are 0.
- Reset asserted mid-operation clears everything immediately (asynchronous). The first tick comes TICK_CYCLES cycles after the first edge with reset=0 and enable=1.
- Press latency: a clean raw level edge produces the stable-level edge 2 (sync) + DEBOUNCE_CYCLES cycles later. The queue push happens on the following edge, and queue_count reflects it on that edge.
- A bounce shorter than DEBOUNCE_CYCLES cycles never produces a press.
- tick period is exactly TICK_CYCLES cycles. move and tick change on the same edge.
- dropped is registered and never high for more than one consecutive cycle per event. Back-to-back events give back-to-back pulses.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4 and TICK_CYCLES=10.

1. Reset release with enable=1 and no buttons → move=5, queue_count=0. tick pulses at cycles 10, 20, 30, with move staying 5.
2. Press right cleanly for 20 cycles → queue_count=1 at press+7. The next tick sets move=2 and queue_count=0.
3. With move=2, press left → dropped pulse, queue_count stays 0. Then press up then left before the next tick → queue_count=2. The next tick gives move=1, the following tick gives move=4.
4. Toggle up every 2 cycles for 30 cycles, then release → no press, queue_count=0, dropped=0.
5. Queue full (2 entries) plus a third valid press → dropped=1 and queue_count stays 2. Push the third press on the same edge as a tick pop → it is accepted, and queue_count stays 2.
6. Assert reset mid-queue (queue_count=2, move=3) → immediately move=5, queue_count=0, tick=0. Drop enable for 15 cycles → no ticks, and the queue is cleared.
